// File: rtl/fastram_dram_sequencer.sv
// rtl/fastram_dram_sequencer.sv - RAS/CAS sequencer with CBR refresh scheduling for the FastRAM DRAM array
//
// Ports:
//   CLK          system clock (CPU clock)
//   RESETn       synchronous active-low reset
//   req          decoded RAM bus cycle, held until the cycle ends
//   req_upper    UDS active (active-high)
//   req_lower    LDS active (active-high)
//   RASn         DRAM row strobe, active-low, registered
//   UCASn        upper-byte column strobe, active-low, registered
//   LCASn        lower-byte column strobe, active-low, registered
//   mux_col      0 = row address on MADDR, 1 = column address, registered
//   ack          access data phase valid (CAS asserted), registered
//   ref_backlog  number of refreshes owed

module fastram_dram_sequencer #(
    parameter int REFRESH_INTERVAL = 108,
    parameter int TRP_CYCLES       = 1,
    parameter int REF_RAS_CYCLES   = 2
) (
    input  logic       CLK,
    input  logic       RESETn,
    input  logic       req,
    input  logic       req_upper,
    input  logic       req_lower,
    output logic       RASn,
    output logic       UCASn,
    output logic       LCASn,
    output logic       mux_col,
    output logic       ack,
    output logic [1:0] ref_backlog
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ROW     = 3'd1;
    localparam logic [2:0] ST_COL     = 3'd2;
    localparam logic [2:0] ST_CAS     = 3'd3;
    localparam logic [2:0] ST_REF_CAS = 3'd4;
    localparam logic [2:0] ST_REF_RAS = 3'd5;
    localparam logic [2:0] ST_PRE     = 3'd6;

    localparam int TW = $clog2(REFRESH_INTERVAL);

    logic [2:0]    state;
    logic [2:0]    state_next;
    logic [1:0]    cnt;
    logic [TW-1:0] timer;
    logic          timer_wrap;
    logic          ref_done;

    assign timer_wrap = (timer == TW'(REFRESH_INTERVAL - 1));
    assign ref_done   = (state == ST_REF_RAS) && (cnt == 2'd0);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                // An access is only taken while the backlog is not full;
                // a full backlog forces a refresh ahead of the CPU.
                if (req && (ref_backlog != 2'd3))
                    state_next = ST_ROW;
                else if (ref_backlog != 2'd0)
                    state_next = ST_REF_CAS;
            end
            ST_ROW:     state_next = req ? ST_COL : ST_PRE;
            ST_COL:     state_next = req ? ST_CAS : ST_PRE;
            ST_CAS:     state_next = req ? ST_CAS : ST_PRE;
            ST_REF_CAS: state_next = ST_REF_RAS;
            ST_REF_RAS: state_next = (cnt == 2'd0) ? ST_PRE : ST_REF_RAS;
            ST_PRE:     state_next = (cnt == 2'd0) ? ST_IDLE : ST_PRE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state       <= ST_IDLE;
            cnt         <= 2'd0;
            timer       <= '0;
            ref_backlog <= 2'd0;
            RASn        <= 1'b1;
            UCASn       <= 1'b1;
            LCASn       <= 1'b1;
            mux_col     <= 1'b0;
            ack         <= 1'b0;
        end else begin
            state <= state_next;

            // Dwell counter: loaded on entry to a timed state, counts down to 0.
            if ((state_next == ST_REF_RAS) && (state != ST_REF_RAS))
                cnt <= 2'(REF_RAS_CYCLES - 1);
            else if ((state_next == ST_PRE) && (state != ST_PRE))
                cnt <= 2'(TRP_CYCLES - 1);
            else if (cnt != 2'd0)
                cnt <= cnt - 2'd1;

            timer <= timer_wrap ? '0 : timer + TW'(1);

            // Simultaneous wrap and refresh completion cancel out.
            case ({timer_wrap, ref_done})
                2'b10:   if (ref_backlog != 2'd3) ref_backlog <= ref_backlog + 2'd1;
                2'b01:   ref_backlog <= ref_backlog - 2'd1;
                default: ref_backlog <= ref_backlog;
            endcase

            // Outputs decoded from the next state so they are registered and
            // change on the same edge as the state. Byte strobes in CAS follow
            // UDS/LDS every cycle so late write strobes are honoured.
            RASn    <= !((state_next == ST_ROW) || (state_next == ST_COL) ||
                         (state_next == ST_CAS) || (state_next == ST_REF_RAS));
            UCASn   <= !(((state_next == ST_CAS) && req_upper) ||
                         (state_next == ST_REF_CAS) || (state_next == ST_REF_RAS));
            LCASn   <= !(((state_next == ST_CAS) && req_lower) ||
                         (state_next == ST_REF_CAS) || (state_next == ST_REF_RAS));
            mux_col <= (state_next == ST_COL) || (state_next == ST_CAS);
            ack     <= (state_next == ST_CAS);
        end
    end

endmodule

// File: doc/fastram_dram_sequencer.md
Name: fastram_dram_sequencer

Overview:
- Owns the RAS/CAS timing for the 8MB FastRAM DRAM array.
- Arbitrates between decoded 68000 access requests and CAS-before-RAS refresh.
- Refresh is scheduled by an internal interval timer with a bounded backlog.
- Sits between the address decode/autoconfig match logic (which supplies `req`) and the DRAM pins and row/column address mux.

Parameters:
- REFRESH_INTERVAL, 108: CLK cycles between refresh requests (15.2 µs at 7.09 MHz).
- TRP_CYCLES, 1: precharge cycles, all strobes high, after every access or refresh; legal range 1–3.
- REF_RAS_CYCLES, 2: cycles RAS is held low during refresh; legal range 1–3.

Ports:
- CLK  in  1  system clock (7.09 MHz CPU clock).
- RESETn  in  1  synchronous active-low reset.
- req  in  1  decoded RAM cycle (address matched, ASn low); held until the bus cycle ends.
- req_upper  in  1  UDS active (active-high).
- req_lower  in  1  LDS active (active-high).
- RASn  out  1  DRAM row strobe, active-low, registered.
- UCASn  out  1  upper-byte column strobe, active-low, registered.
- LCASn  out  1  lower-byte column strobe, active-low, registered.
- mux_col  out  1  0 = row address on MADDR, 1 = column address; registered.
- ack  out  1  access data phase valid (CAS asserted), registered.
- ref_backlog  out  2  number of refreshes owed, for debug/verification.

Behaviour:
- All state changes on the rising edge of CLK. RESETn low at an edge sets the following: state IDLE, RASn=UCASn=LCASn=1, mux_col=0, ack=0, timer=0, ref_backlog=0.
- Reset mid-operation: strobes go high at that same edge. No partial cycle resumes after reset.
- Refresh timer:
  - Counts 0..REFRESH_INTERVAL-1, then wraps to 0.
  - At the wrap, ref_backlog increments, saturating at 3.
  - If a wrap coincides with a refresh completion (decrement), ref_backlog is unchanged.
  - The timer free-runs in every state.
- States: IDLE, ROW, COL, CAS, REF_CAS, REF_RAS, PRE.
- IDLE (all strobes high, mux_col=0):
  - req=1 and ref_backlog<3 → ROW.
  - Otherwise ref_backlog>0 → REF_CAS. When req=1 and ref_backlog=3, refresh wins.
  - Otherwise stay in IDLE.
- ROW: RASn=0, mux_col=0, one cycle → COL. If req=0 → PRE.
- COL: RASn=0, mux_col=1, one cycle → CAS. If req=0 → PRE, no CAS and no ack.
- CAS:
  - RASn=0, mux_col=1, ack=1, UCASn=!req_upper, LCASn=!req_lower.
  - Strobes re-evaluated every cycle so late UDS/LDS on writes is honoured.
  - Stay while req=1. req=0 → PRE, all outputs deassert at that edge.
- REF_CAS: UCASn=LCASn=0, RASn=1, one cycle → REF_RAS.
- REF_RAS: all three strobes low for REF_RAS_CYCLES → PRE. ref_backlog decrements on exit.
- PRE: all strobes high, ack=0, mux_col=0, for TRP_CYCLES → IDLE.
- req arriving during REF_CAS, REF_RAS or PRE waits. It is served from IDLE per the priority rule above.
- Minimum access latency: req sampled high in IDLE → ack high 3 edges later (ROW, COL, CAS).
- RAS is never asserted without a preceding PRE or IDLE cycle. CAS is never asserted in ROW.

Test Plan:
- Reset then idle 108 cycles → ref_backlog=1 at cycle 108. Refresh sequence: REF_CAS 1 cycle, RAS+CAS low 2 cycles, PRE 1 cycle. ref_backlog back to 0.
- Word read, req and both strobes held 6 cycles from IDLE → RASn low at edge 1, mux_col=1 at edge 2, ack and both CAS low at edge 3. All high one edge after req drops.
- Byte write with req_lower only, req_upper rising one cycle into CAS → LCASn low at CAS entry, UCASn low one cycle later.
- Hold req continuously for 4×108 cycles → ref_backlog saturates at 3. The next IDLE with req=1 runs a refresh before ROW.
- Timer wrap in the same cycle REF_RAS exits → ref_backlog unchanged.
- Assert RESETn=0 during CAS → next edge: all strobes high, ack=0, state IDLE, timer=0.
